// File: rtl/can_bit_sampler_if.sv
// Bus bundle between the CAN bit sampler and its consumers (size / ID detectors).
// The master drives the pin, enable and rate select; the slave is the sampler itself.
interface can_bit_sampler_if;
  logic enable;
  logic canRx;
  logic rateSelector;
  logic samplePulse;
  logic dIn;
  logic sofDetected;
  logic busIdle;

  modport master (
    output enable, canRx, rateSelector,
    input  samplePulse, dIn, sofDetected, busIdle
  );

  modport slave (
    input  enable, canRx, rateSelector,
    output samplePulse, dIn, sofDetected, busIdle
  );
endinterface

// File: rtl/can_bit_sampler.sv
// CAN bit-timing front end: RX synchroniser, bus-idle tracking, SOF hard sync, SJW resync.
// Optional glitch filter on the synchronised RX level: define CAN_SAMPLER_GLITCH_FILTER_EN.
module can_bit_sampler #(
  parameter int CLK_PER_TQ = 5,
  parameter int TQ_PER_BIT = 20,
  parameter int SAMPLE_TQ  = 15,
  parameter int SJW        = 1
) (
  input logic               clk,
  input logic               reset,
  can_bit_sampler_if.slave  bus
);

  localparam int IDLE_CLKS = 11 * TQ_PER_BIT * CLK_PER_TQ;
  localparam int IDLE_W    = $clog2(IDLE_CLKS + 1);
  localparam int PRESC_W   = $clog2(CLK_PER_TQ);
  localparam int TQ_W      = $clog2(TQ_PER_BIT);
  localparam int HOLD_W    = 3;

  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_CLKS);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_TQ - 1);
  localparam logic [TQ_W-1:0]    TQ_LAST    = TQ_W'(TQ_PER_BIT - 1);
  localparam logic [TQ_W-1:0]    SAMP_A     = TQ_W'(SAMPLE_TQ - 2);
  localparam logic [TQ_W-1:0]    SAMP_B     = TQ_W'(SAMPLE_TQ - 1);
  localparam logic [TQ_W-1:0]    SAMP_C     = TQ_W'(SAMPLE_TQ);
  localparam logic [TQ_W-1:0]    EARLY_END  = TQ_W'(TQ_PER_BIT - SJW);
  localparam logic [TQ_W-1:0]    SJW_TQ     = TQ_W'(SJW);
  localparam logic [HOLD_W-1:0]  SJW_H      = HOLD_W'(SJW);
  localparam logic [TQ_W:0]      TQ_COUNT   = (TQ_W+1)'(TQ_PER_BIT);

  typedef enum logic [1:0] {
    s_idle     = 2'd0,
    s_wait_sof = 2'd1,
    s_frame    = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                rx_s_q, rx_s_d;
  logic                rx_prev_q, rx_prev_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TQ_W-1:0]     tq_q, tq_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                resync_done_q, resync_done_d;
  logic                rate_q, rate_d;
  logic                samp0_q, samp0_d;
  logic                samp1_q, samp1_d;
  logic                sample_pulse_q, sample_pulse_d;
  logic                d_in_q, d_in_d;
  logic                sof_q, sof_d;
`ifdef CAN_SAMPLER_GLITCH_FILTER_EN
  logic                rx_filt_q, rx_filt_d;
`endif

  logic                rx_lvl_s;
  logic                f_edge_s;
  logic                bus_idle_s;
  logic                tq_tick_s;
  logic                bit_wrap_s;
  logic                do_resync_s;
  logic                late_s;
  logic                early_s;
  logic [HOLD_W-1:0]   hold_eff_s;
  logic [TQ_W:0]       tq_sum_s;

  // Next-state logic for the synchroniser, idle counter, time base and sampling FSM.
  always_comb begin
    sync1_d   = bus.canRx;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
`ifdef CAN_SAMPLER_GLITCH_FILTER_EN
    // The filtered level only follows rxS once two consecutive samples agree.
    rx_lvl_s  = (rx_s_q == rx_prev_q) ? rx_s_q : rx_filt_q;
    f_edge_s  = rx_filt_q & ~rx_lvl_s;
    rx_filt_d = rx_lvl_s;
`else
    rx_lvl_s  = rx_s_q;
    f_edge_s  = rx_prev_q & ~rx_s_q;
`endif

    bus_idle_s = (idle_cnt_q == IDLE_MAX);
    if (!rx_lvl_s) begin
      idle_cnt_d = '0;
    end else if (!bus_idle_s) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    state_d        = state_q;
    presc_d        = presc_q;
    tq_d           = tq_q;
    hold_d         = hold_q;
    resync_done_d  = resync_done_q;
    rate_d         = rate_q;
    samp0_d        = samp0_q;
    samp1_d        = samp1_q;
    sample_pulse_d = 1'b0;
    d_in_d         = d_in_q;
    sof_d          = 1'b0;
    tq_tick_s      = (presc_q == PRESC_LAST);
    bit_wrap_s     = 1'b0;
    do_resync_s    = 1'b0;
    late_s         = 1'b0;
    early_s        = 1'b0;
    hold_eff_s     = hold_q;
    tq_sum_s       = '0;

    case (state_q)
      s_idle: begin
        presc_d       = '0;
        tq_d          = '0;
        hold_d        = '0;
        resync_done_d = 1'b0;
        if (bus_idle_s) begin
          state_d = s_wait_sof;
        end else begin
          state_d = s_idle;
        end
      end
      s_wait_sof: begin
        presc_d       = '0;
        tq_d          = '0;
        hold_d        = '0;
        resync_done_d = 1'b0;
        if (f_edge_s) begin
          sof_d   = 1'b1;
          state_d = s_frame;
        end else begin
          state_d = s_wait_sof;
        end
      end
      s_frame: begin
        if (presc_q == '0 && tq_q == '0) begin
          rate_d = bus.rateSelector;
        end else begin
          rate_d = rate_q;
        end
        if (presc_q == '0 && rate_q && tq_q == SAMP_A) begin
          sample_pulse_d = 1'b1;
          samp0_d        = rx_s_q;
        end else if (presc_q == '0 && rate_q && tq_q == SAMP_B) begin
          sample_pulse_d = 1'b1;
          samp1_d        = rx_s_q;
        end else if (presc_q == '0 && tq_q == SAMP_C) begin
          sample_pulse_d = 1'b1;
          d_in_d         = rate_q ? maj3(samp0_q, samp1_q, rx_s_q) : rx_s_q;
        end else begin
          sample_pulse_d = 1'b0;
        end

        do_resync_s = f_edge_s & ~resync_done_q & (tq_q != '0);
        late_s      = do_resync_s & (tq_q < SAMP_A);
        early_s     = do_resync_s & (tq_q > SAMP_C);
        // A late edge repeats the current TQ; applying it now keeps a repeat off the sample TQs.
        if (late_s) begin
          hold_eff_s = (tq_q < SJW_TQ) ? tq_q[HOLD_W-1:0] : SJW_H;
        end else begin
          hold_eff_s = hold_q;
        end

        if (tq_tick_s) begin
          presc_d = '0;
          if (hold_eff_s != '0) begin
            tq_d   = tq_q;
            hold_d = hold_eff_s - HOLD_W'(1);
          end else if (tq_q == TQ_LAST) begin
            tq_d       = '0;
            hold_d     = '0;
            bit_wrap_s = 1'b1;
          end else begin
            tq_d   = tq_q + TQ_W'(1);
            hold_d = '0;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
          tq_d    = tq_q;
          hold_d  = hold_eff_s;
        end
        resync_done_d = bit_wrap_s ? 1'b0 : (resync_done_q | late_s);

        if (early_s) begin
          if (tq_q >= EARLY_END) begin
            tq_d          = '0;
            presc_d       = '0;
            hold_d        = '0;
            resync_done_d = 1'b0;
          end else begin
            tq_sum_s = {1'b0, tq_d} + {1'b0, SJW_TQ};
            if (tq_sum_s >= TQ_COUNT) begin
              tq_d          = '0;
              presc_d       = '0;
              resync_done_d = 1'b0;
            end else begin
              tq_d          = tq_sum_s[TQ_W-1:0];
              resync_done_d = 1'b1;
            end
          end
        end else begin
          tq_sum_s = '0;
        end

        if (bus_idle_s) begin
          state_d = s_wait_sof;
        end else begin
          state_d = s_frame;
        end
      end
      default: begin
        state_d = s_idle;
      end
    endcase

    // Dropping enable abandons the bit in progress; dIn keeps its last value.
    if (!bus.enable) begin
      state_d        = s_idle;
      sample_pulse_d = 1'b0;
      sof_d          = 1'b0;
      d_in_d         = d_in_q;
      samp0_d        = 1'b1;
      samp1_d        = 1'b1;
      presc_d        = '0;
      tq_d           = '0;
      hold_d         = '0;
      resync_done_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= s_idle;
      sync1_q        <= 1'b0;
      rx_s_q         <= 1'b0;
      rx_prev_q      <= 1'b0;
      idle_cnt_q     <= '0;
      presc_q        <= '0;
      tq_q           <= '0;
      hold_q         <= '0;
      resync_done_q  <= 1'b0;
      rate_q         <= 1'b0;
      samp0_q        <= 1'b1;
      samp1_q        <= 1'b1;
      sample_pulse_q <= 1'b0;
      d_in_q         <= 1'b1;
      sof_q          <= 1'b0;
`ifdef CAN_SAMPLER_GLITCH_FILTER_EN
      rx_filt_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      rx_s_q         <= rx_s_d;
      rx_prev_q      <= rx_prev_d;
      idle_cnt_q     <= idle_cnt_d;
      presc_q        <= presc_d;
      tq_q           <= tq_d;
      hold_q         <= hold_d;
      resync_done_q  <= resync_done_d;
      rate_q         <= rate_d;
      samp0_q        <= samp0_d;
      samp1_q        <= samp1_d;
      sample_pulse_q <= sample_pulse_d;
      d_in_q         <= d_in_d;
      sof_q          <= sof_d;
`ifdef CAN_SAMPLER_GLITCH_FILTER_EN
      rx_filt_q      <= rx_filt_d;
`endif
    end
  end

  assign bus.samplePulse = sample_pulse_q;
  assign bus.dIn         = d_in_q;
  assign bus.sofDetected = sof_q;
  assign bus.busIdle     = bus_idle_s;

endmodule

// File: doc/can_bit_sampler.md
Name: can_bit_sampler

Overview:
- Front-end bit-timing stage that drives the CAN size detector and the CAN ID detector.
- Synchronises the raw CAN RX pin and tracks bus idle.
- Hard-syncs on SOF and resynchronises on recessive-to-dominant edges within SJW.
- Emits single-cycle samplePulse strobes (1 or 3 per bit) with a held sampled bit value dIn.

Parameters:
CLK_PER_TQ, 5, clocks per time quantum (prescaler); minimum 2
TQ_PER_BIT, 20, time quanta per nominal bit (100 clk/bit at defaults = 1 Mb/s at 100 MHz)
SAMPLE_TQ, 15, TQ index of the final sample point; legal range 3..TQ_PER_BIT-2
SJW, 1, resync jump width in TQ; legal range 1..4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 forces s_idle and suppresses all strobes
canRx  in  1  asynchronous CAN RX pin (1 = recessive)
rateSelector  in  1  1 = three sample points per bit, 0 = one
samplePulse  out  1  single-cycle strobe at each sample point
dIn  out  1  sampled bit value (majority of 3 in triple mode); held between updates
sofDetected  out  1  single-cycle pulse on the hard-sync cycle
busIdle  out  1  1 while 11 recessive bit times have elapsed with no dominant level

Behaviour:
- Reset values: samplePulse=0, sofDetected=0, busIdle=0, dIn=1, state s_idle; prescCnt=tqCnt=idleCnt=0.
- Input path: 2-flop synchroniser feeding rxS; rxPrev is rxS delayed by 1 clock.
  - Falling edge fEdge = rxPrev & ~rxS.
  - An external edge at cycle E is seen as fEdge at E+2.
- Idle counter:
  - Increments each clock while rxS=1; clears to 0 when rxS=0.
  - Saturates at IDLE_CLKS = 11*TQ_PER_BIT*CLK_PER_TQ.
  - busIdle is combinational (idleCnt==IDLE_CLKS).
- Time base:
  - prescCnt runs 0..CLK_PER_TQ-1; tqTick when prescCnt==CLK_PER_TQ-1.
  - tqCnt runs 0..TQ_PER_BIT-1 and advances on tqTick, wrapping to 0 (wrap = bit boundary).
- FSM:
  - s_idle: no strobes. Goes to s_waitSof when busIdle=1 and enable=1.
  - s_waitSof: on fEdge, performs a hard sync and goes to s_frame.
    - In the fEdge cycle: sofDetected=1.
    - Next cycle: prescCnt=0, tqCnt=0.
  - s_frame: bit timing active. Goes back to s_waitSof when busIdle rises.
  - Any state goes to s_idle when enable=0, next cycle; partially accumulated samples are discarded and dIn is held.
- Sample points:
  - samplePulse fires on the first clock of TQ SAMPLE_TQ-2, SAMPLE_TQ-1 and SAMPLE_TQ when rateSelector=1.
  - It fires on TQ SAMPLE_TQ only when rateSelector=0.
  - Samples use rxS.
  - dIn updates in the same cycle as the final pulse: majority of 3 in triple mode, the sample itself in single mode.
  - rateSelector is sampled once per bit at tqCnt==0; a mid-bit change takes effect from the next bit.
- Resync (s_frame only, fEdge, at most once per bit, none at tqCnt==0):
  - Edge at tqCnt=t with 0<t<SAMPLE_TQ-2 (late): phase segment 1 is lengthened by min(t,SJW) TQ.
    - Implemented by holding tqCnt for that many extra TQ.
  - Edge at t>SAMPLE_TQ (early): e = TQ_PER_BIT-t; phase segment 2 is shortened by min(e,SJW) TQ.
    - If e<=SJW, the bit ends immediately: the next cycle is tqCnt=0, prescCnt=0.
  - Edge in t = SAMPLE_TQ-2..SAMPLE_TQ: no resync.
- Simultaneous events:
  - fEdge in the same cycle as a sample pulse: the pulse is emitted with the pre-edge rxS, and the resync applies afterwards.
  - reset has priority over everything.

Optional Feature:
- Macro: CAN_SAMPLER_GLITCH_FILTER_EN.
- When defined:
  - rxS must be stable for 2 consecutive clocks before any edge is recognised.
  - fEdge is raised 1 clock later than without the filter.
  - A single-clock dominant glitch produces no sofDetected, resync or idle-counter clear.
- When undefined: every synchronised transition is an edge.

Test Plan:
- Defaults, reset, canRx=1 held → busIdle=0 through clock 1101 after reset release, busIdle=1 at clock 1102 (2-clock sync + 1100).
- Bus idle, rateSelector=0, canRx falls at cycle E → sofDetected=1 at E+2, samplePulse at E+78 with dIn=0, next samplePulse at E+178.
- Same with rateSelector=1 → samplePulses at E+68, E+73, E+78; dIn changes only at E+78.
  - With canRx pulsed high only across E+72..E+73, dIn is still 0 (majority).
- Late edge (t=5) in frame with SJW=1 → following sample point occurs 5 clocks (one TQ) later than nominal.
- Early edge at t=19 with SJW=1 → bit ends immediately; next sample point at edge+2+1+75.
- enable dropped mid-bit → no samplePulse from next cycle; dIn held.
  - With CAN_SAMPLER_GLITCH_FILTER_EN, a 1-clock dominant glitch while idle gives sofDetected=0 and busIdle stays 1.
